// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg
// Shared definitions for the run/halt/single-step sequencer:
//   - state_t   : FSM state encoding (IDLE, RUN, HALT, RESUME, STEP)
//   - DEBOUNCE_DEFAULT / DB_W_DEFAULT : board-level debounce defaults
//   - rise()    : 0->1 edge detect helper used by the button conditioners
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_HALT   = 3'd2,
        S_RESUME = 3'd3,
        S_STEP   = 3'd4
    } state_t;

    // One million stable samples is roughly 10-20 ms at typical board clocks.
    localparam int unsigned DEBOUNCE_DEFAULT = 32'd1_000_000;
    localparam int unsigned DB_W_DEFAULT     = 32'd20;

    // Rising-edge detect between the current and previous accepted level.
    function automatic logic rise(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/run_ctrl_btn_pulse.sv
// btn_pulse
// Conditions one raw push-button into a single-cycle press pulse:
// 2-FF synchronizer, counter-based debounce, registered 0->1 pulse.
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   btn   in   raw asynchronous button level
//   pulse out  one-cycle pulse on each accepted press (registered)
module btn_pulse
    import run_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned DB_W            = DB_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    // Count value reached on the last disagreeing sample of a full window.
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 32'd1);

    logic            sync1_r;
    logic            sync2_r;
    logic            level_r;
    logic            level_q_r;
    logic            pulse_r;
    logic [DB_W-1:0] db_cnt_r;
    logic            differ_s;
    logic            expire_s;

    assign differ_s = sync2_r ^ level_r;
    assign expire_s = (db_cnt_r == DB_LAST);
    assign pulse    = pulse_r;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: any agreeing sample restarts the window; a full window of
    // disagreeing samples adopts the synchronized level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_r <= {DB_W{1'b0}};
            level_r  <= 1'b0;
        end else if (!differ_s) begin
            db_cnt_r <= {DB_W{1'b0}};
            level_r  <= level_r;
        end else if (expire_s) begin
            db_cnt_r <= {DB_W{1'b0}};
            level_r  <= sync2_r;
        end else begin
            db_cnt_r <= db_cnt_r + DB_W'(1'b1);
            level_r  <= level_r;
        end
    end

    // Registered pulse on a 0->1 change of the accepted level only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q_r <= 1'b0;
            pulse_r   <= 1'b0;
        end else begin
            level_q_r <= level_r;
            pulse_r   <= rise(level_r, level_q_r);
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl
// Run/halt/single-step sequencer between the board buttons and the PC.
// Ports:
//   clk        in   system clock (single domain)
//   rst        in   asynchronous active-high reset
//   go_btn     in   raw GO button
//   step_btn   in   raw STEP button
//   halt_req   in   current instruction is a halting syscall
//   halt_en    in   board switch, 1 = honour halt_req
//   pc_en      out  PC write enable (combinational from state/halt inputs)
//   running    out  registered: state is RUN or RESUME
//   halted     out  registered: state is HALT
//   instr_cnt  out  number of cycles with pc_en=1, wraps silently
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned DB_W            = DB_W_DEFAULT,
    parameter int unsigned CNT_W           = 32'd32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go_btn,
    input  logic             step_btn,
    input  logic             halt_req,
    input  logic             halt_en,
    output logic             pc_en,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t           state_r;
    state_t           next_state_s;
    logic             pc_en_s;
    logic             go_p_s;
    logic             step_p_s;
    logic             running_r;
    logic             halted_r;
    logic [CNT_W-1:0] instr_cnt_r;

    btn_pulse #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_W            (DB_W)
    ) u_go (
        .clk   (clk),
        .rst   (rst),
        .btn   (go_btn),
        .pulse (go_p_s)
    );

    btn_pulse #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_W            (DB_W)
    ) u_step (
        .clk   (clk),
        .rst   (rst),
        .btn   (step_btn),
        .pulse (step_p_s)
    );

    // Next-state and PC enable decode; RESUME and STEP advance the PC
    // unconditionally so a halting syscall can be stepped past.
    always_comb begin
        next_state_s = state_r;
        pc_en_s      = 1'b0;
        case (state_r)
            S_IDLE, S_HALT: begin
                // GO takes priority when both buttons land together.
                if (go_p_s) begin
                    next_state_s = S_RESUME;
                end else if (step_p_s) begin
                    next_state_s = S_STEP;
                end else begin
                    next_state_s = state_r;
                end
            end
            S_RUN: begin
                if (halt_req && halt_en) begin
                    next_state_s = S_HALT;
                    pc_en_s      = 1'b0;
                end else begin
                    next_state_s = S_RUN;
                    pc_en_s      = 1'b1;
                end
            end
            S_RESUME: begin
                next_state_s = S_RUN;
                pc_en_s      = 1'b1;
            end
            S_STEP: begin
                next_state_s = S_HALT;
                pc_en_s      = 1'b1;
            end
            default: begin
                next_state_s = S_IDLE;
                pc_en_s      = 1'b0;
            end
        endcase
    end

    // State register; status LEDs decode the next state so they line up
    // with the state itself while staying glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            running_r <= 1'b0;
            halted_r  <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            running_r <= (next_state_s == S_RUN) || (next_state_s == S_RESUME);
            halted_r  <= (next_state_s == S_HALT);
        end
    end

    // Retired-instruction counter, free-running wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_cnt_r <= {CNT_W{1'b0}};
        end else if (pc_en_s) begin
            instr_cnt_r <= instr_cnt_r + CNT_W'(1'b1);
        end else begin
            instr_cnt_r <= instr_cnt_r;
        end
    end

    assign pc_en     = pc_en_s;
    assign running   = running_r;
    assign halted    = halted_r;
    assign instr_cnt = instr_cnt_r;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl
// Scoreboard bench for run_ctrl (DEBOUNCE_CYCLES=4, DB_W=3, CNT_W=8).
// Stimulus queues the expected status tuple {running, halted, pc_en},
// instr_cnt and (where known) the cycle number of every status change;
// the monitor pops and compares whenever the tuple changes.
module tb_run_ctrl;

    typedef struct {
        logic [2:0] st;
        logic [7:0] cnt;
        int         at;
        string      nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       go_btn;
    logic       step_btn;
    logic       halt_req;
    logic       halt_en;
    logic       pc_en;
    logic       running;
    logic       halted;
    logic [7:0] instr_cnt;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   first  = 1'b1;
    bit   done   = 1'b0;
    logic [2:0] last = 3'b000;
    exp_t sb[$];

    run_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .DB_W            (3),
        .CNT_W           (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .go_btn    (go_btn),
        .step_btn  (step_btn),
        .halt_req  (halt_req),
        .halt_en   (halt_en),
        .pc_en     (pc_en),
        .running   (running),
        .halted    (halted),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input logic [2:0] st, input logic [7:0] cnt,
                             input int at, input string nm);
        exp_t e;
        e.st  = st;
        e.cnt = cnt;
        e.at  = at;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic press(input logic g, input logic s, input int hold);
        go_btn   = g;
        step_btn = s;
        tick(hold);
        go_btn   = 1'b0;
        step_btn = 1'b0;
    endtask

    // Monitor: compare on every change of the status tuple.
    always @(negedge clk) begin
        logic [2:0] cur;
        exp_t       e;
        cur = {running, halted, pc_en};
        if (done) begin
            checks = checks + 1;
            if (sb.size() != 0) begin
                errors = errors + 1;
                $display("FAIL pending_events: got %0d unobserved, required 0", sb.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end else if (first || (cur != last)) begin
            checks = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_change: got st=%b cnt=%h cyc=%0d, required no change",
                         cur, instr_cnt, cyc);
            end else begin
                e = sb.pop_front();
                if ((cur != e.st) || (instr_cnt != e.cnt) || ((e.at >= 0) && (cyc != e.at))) begin
                    errors = errors + 1;
                    $display("FAIL %s: got st=%b cnt=%h cyc=%0d, required st=%b cnt=%h cyc=%0d",
                             e.nm, cur, instr_cnt, cyc, e.st, e.cnt, e.at);
                end
            end
            first = 1'b0;
            last  = cur;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int t;
        rst      = 1'b1;
        go_btn   = 1'b0;
        step_btn = 1'b0;
        halt_req = 1'b0;
        halt_en  = 1'b1;
        expect_ev(3'b000, 8'h00, -1, "reset_state");
        tick(3);
        rst = 1'b0;
        tick(3);

        // Clean GO press: RESUME 8 edges after the drive point, then counting.
        c = cyc;
        t = c + 8;
        expect_ev(3'b101, 8'd0, t, "go_latency_resume");
        press(1'b1, 1'b0, 6);
        tick_to(t + 20);
        halt_req = 1'b1;
        expect_ev(3'b100, 8'd20, cyc, "halt_pc_en_same_cycle");
        expect_ev(3'b010, 8'd20, cyc + 1, "halted_next_edge");
        tick(12);

        // GO with halt_req held: one RESUME cycle, one blocked RUN cycle, HALT.
        c = cyc;
        expect_ev(3'b101, 8'd20, c + 8, "resume_past_halt");
        expect_ev(3'b100, 8'd21, c + 9, "run_blocked_by_halt");
        expect_ev(3'b010, 8'd21, c + 10, "rehalt");
        press(1'b1, 1'b0, 6);
        tick(14);

        // Three single steps from HALT, halt_req still high.
        for (int i = 0; i < 3; i++) begin
            c = cyc;
            expect_ev(3'b001, 8'(21 + i), c + 8, "step_pulse");
            expect_ev(3'b010, 8'(22 + i), c + 9, "step_back_to_halt");
            press(1'b0, 1'b1, 6);
            tick(14);
        end

        // halt_en=0 ignores halt_req in RUN; re-enabling halts at once.
        halt_en = 1'b0;
        c = cyc;
        t = c + 8;
        expect_ev(3'b101, 8'd24, t, "resume_halt_en_off");
        press(1'b1, 1'b0, 6);
        tick_to(t + 15);
        halt_en = 1'b1;
        expect_ev(3'b100, 8'd39, cyc, "halt_en_on_same_cycle");
        expect_ev(3'b010, 8'd39, cyc + 1, "halted_after_halt_en");
        tick(12);

        // Bouncing GO: no pulse while toggling, exactly one after a stable hold.
        for (int i = 0; i < 5; i++) begin
            go_btn = 1'b1;
            tick(2);
            go_btn = 1'b0;
            tick(2);
        end
        c = cyc;
        expect_ev(3'b101, 8'd39, c + 8, "bounce_single_go");
        expect_ev(3'b100, 8'd40, c + 9, "bounce_run_blocked");
        expect_ev(3'b010, 8'd40, c + 10, "bounce_rehalt");
        press(1'b1, 1'b0, 6);
        tick(14);

        // GO and STEP together from HALT: GO wins.
        c = cyc;
        expect_ev(3'b101, 8'd40, c + 8, "go_wins_over_step");
        expect_ev(3'b100, 8'd41, c + 9, "go_wins_run");
        expect_ev(3'b010, 8'd41, c + 10, "go_wins_rehalt");
        press(1'b1, 1'b1, 6);
        tick(14);

        // Counter wrap: run up to FF, then a step rolls it to 00.
        halt_req = 1'b0;
        c = cyc;
        t = c + 8;
        expect_ev(3'b101, 8'd41, t, "resume_for_wrap");
        press(1'b1, 1'b0, 6);
        tick_to(t + 214);
        halt_req = 1'b1;
        expect_ev(3'b100, 8'hFF, cyc, "count_ff");
        expect_ev(3'b010, 8'hFF, cyc + 1, "halt_at_ff");
        tick(4);
        c = cyc;
        expect_ev(3'b001, 8'hFF, c + 8, "step_at_ff");
        expect_ev(3'b010, 8'h00, c + 9, "wrap_to_00");
        press(1'b0, 1'b1, 6);
        tick(14);
        c = cyc;
        expect_ev(3'b001, 8'h00, c + 8, "step_at_00");
        expect_ev(3'b010, 8'h01, c + 9, "count_01");
        press(1'b0, 1'b1, 6);
        tick(14);

        // Short reset pulse between edges during STEP: async clear, no increment.
        c = cyc;
        expect_ev(3'b001, 8'h01, c + 8, "step_before_reset");
        expect_ev(3'b000, 8'h00, c + 9, "reset_mid_step");
        press(1'b0, 1'b1, 6);
        tick_to(c + 8);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick(6);
        done = 1'b1;
    end

endmodule
